// File: rtl/tpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_pkg : loader state encoding, header tag and instruction-memory sizing
// Rev 1.0
// ---------------------------------------------------------------------------
package tpu_pkg;

  localparam int MAX_INSTR = 64;
  localparam int ADDR_W    = $clog2(MAX_INSTR);

  localparam logic [1:0] HDR_TAG = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECV_HI   = 3'd1,
    RECV_LO   = 3'd2,
    RECV_CSUM = 3'd3,
    START     = 3'd4,
    RUN       = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_loader_if : host byte stream, sequencer handshake, imem write port
// Rev 1.0
// ---------------------------------------------------------------------------
interface instruction_loader_if;
  import tpu_pkg::*;

  logic [7:0]        host_data;
  logic              host_valid;
  logic              host_ready;
  logic              exec_done;
  logic              fetch_ins;
  logic [ADDR_W-1:0] dma_address;
  logic [15:0]       ui_in;
  logic              start;
  logic              busy;
  logic              load_error;

  modport master (
    output host_data, host_valid, exec_done,
    input  host_ready, fetch_ins, dma_address, ui_in, start, busy, load_error
  );

  modport slave (
    input  host_data, host_valid, exec_done,
    output host_ready, fetch_ins, dma_address, ui_in, start, busy, load_error
  );

endinterface
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_loader : receives a checksummed frame of 16-bit instructions,
// writes them to instruction memory, then launches and waits on execution.
// Rev 1.0
// ---------------------------------------------------------------------------
module instruction_loader
  import tpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  instruction_loader_if.slave bus
);

  loader_state_t     state;
  loader_state_t     state_next;

  logic [ADDR_W-1:0] last_index;
  logic [ADDR_W-1:0] word_index;
  logic [7:0]        csum;
  logic [7:0]        hi_byte;
  logic              fetch_strobe;
  logic [ADDR_W-1:0] write_addr;
  logic [15:0]       write_word;
  logic              error_flag;

  logic              ready;
  logic              xfer;
  logic              hdr_ok;

  assign ready  = reset && (state inside {IDLE, RECV_HI, RECV_LO, RECV_CSUM});
  assign xfer   = bus.host_valid && ready;
  assign hdr_ok = (bus.host_data[7:6] == HDR_TAG);

  assign bus.host_ready  = ready;
  assign bus.busy        = reset && (state != IDLE);
  assign bus.start       = reset && (state == START);
  assign bus.fetch_ins   = fetch_strobe;
  assign bus.dma_address = write_addr;
  assign bus.ui_in       = write_word;
  assign bus.load_error  = error_flag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer && hdr_ok) begin
          state_next = RECV_HI;
        end
      end
      RECV_HI: begin
        if (xfer) begin
          state_next = RECV_LO;
        end
      end
      RECV_LO: begin
        if (xfer) begin
          state_next = (word_index == last_index) ? RECV_CSUM : RECV_HI;
        end
      end
      RECV_CSUM: begin
        if (xfer) begin
          state_next = (bus.host_data == csum) ? START : IDLE;
        end
      end
      START: begin
        state_next = RUN;
      end
      RUN: begin
        if (bus.exec_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The index saturates at the final word so a 64-word frame never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_index   <= '0;
      word_index   <= '0;
      csum         <= '0;
      hi_byte      <= '0;
      fetch_strobe <= 1'b0;
      write_addr   <= '0;
      write_word   <= '0;
      error_flag   <= 1'b0;
    end else begin
      fetch_strobe <= 1'b0;
      if (xfer) begin
        case (state)
          IDLE: begin
            if (hdr_ok) begin
              last_index <= bus.host_data[ADDR_W-1:0];
              word_index <= '0;
              csum       <= '0;
              error_flag <= 1'b0;
            end else begin
              error_flag <= 1'b1;
            end
          end
          RECV_HI: begin
            hi_byte <= bus.host_data;
            csum    <= csum ^ bus.host_data;
          end
          RECV_LO: begin
            fetch_strobe <= 1'b1;
            write_addr   <= word_index;
            write_word   <= {hi_byte, bus.host_data};
            csum         <= csum ^ bus.host_data;
            if (word_index != last_index) begin
              word_index <= word_index + 1'b1;
            end
          end
          RECV_CSUM: begin
            if (bus.host_data != csum) begin
              error_flag <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instruction_loader : directed frames against the instruction loader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instruction_loader;
  import tpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instruction_loader_if bus ();

  instruction_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [5:0]  addr_log[$];
  logic [15:0] data_log[$];
  int          start_pulses = 0;
  int          overlaps = 0;

  always @(negedge clk) begin
    if (bus.fetch_ins === 1'b1) begin
      addr_log.push_back(bus.dma_address);
      data_log.push_back(bus.ui_in);
    end
    if (bus.start === 1'b1) start_pulses++;
    if (bus.start === 1'b1 && bus.fetch_ins === 1'b1) overlaps++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic accepted;
    int   waited;
    bus.host_data  = b;
    bus.host_valid = 1'b1;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 50) begin
      accepted = bus.host_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.host_valid = 1'b0;
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL send_byte_timeout: host_ready=0 required 1 (byte %h)", b);
    end
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 2);
    bus.host_valid = 1'b0;
    repeat (gap) tick(1);
    send_byte(b);
  endtask

  task automatic finish_run();
    bus.exec_done = 1'b1;
    tick(1);
    bus.exec_done = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    tests++; if (bus.host_ready !== 1'b0) begin fails++; $display("FAIL reset_host_ready: got %b want 0", bus.host_ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.fetch_ins !== 1'b0 || bus.start !== 1'b0) begin fails++; $display("FAIL reset_strobes: fetch=%b start=%b want 0 0", bus.fetch_ins, bus.start); end
    tests++; if (bus.load_error !== 1'b0) begin fails++; $display("FAIL reset_load_error: got %b want 0", bus.load_error); end
    tests++; if (bus.dma_address !== 6'd0 || bus.ui_in !== 16'h0000) begin fails++; $display("FAIL reset_bus: addr=%h ui=%h want 0 0", bus.dma_address, bus.ui_in); end
    reset = 1'b1;
    tick(1);
    tests++; if (bus.host_ready !== 1'b1) begin fails++; $display("FAIL idle_host_ready: got %b want 1", bus.host_ready); end
  endtask

  task automatic test_good_frame();
    int fb, sb;
    fb = addr_log.size();
    sb = start_pulses;
    send_byte(8'h81); send_byte(8'h20); send_byte(8'h80);
    send_byte(8'h60); send_byte(8'h00); send_byte(8'hC0);
    tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL good_start_now: got %b want 1", bus.start); end
    tick(4);
    tests++; if (addr_log.size() - fb !== 2) begin fails++; $display("FAIL good_fetch_count: got %0d want 2", addr_log.size() - fb); end
    tests++; if (addr_log[fb] !== 6'd0 || data_log[fb] !== 16'h2080) begin fails++; $display("FAIL good_word0: addr=%h data=%h want 00 2080", addr_log[fb], data_log[fb]); end
    tests++; if (addr_log[fb+1] !== 6'd1 || data_log[fb+1] !== 16'h6000) begin fails++; $display("FAIL good_word1: addr=%h data=%h want 01 6000", addr_log[fb+1], data_log[fb+1]); end
    tests++; if (start_pulses - sb !== 1) begin fails++; $display("FAIL good_start_count: got %0d want 1", start_pulses - sb); end
    tests++; if (bus.busy !== 1'b1 || bus.host_ready !== 1'b0) begin fails++; $display("FAIL good_run_state: busy=%b ready=%b want 1 0", bus.busy, bus.host_ready); end
    tests++; if (bus.dma_address !== 6'd1 || bus.ui_in !== 16'h6000) begin fails++; $display("FAIL good_hold: addr=%h ui=%h want 01 6000", bus.dma_address, bus.ui_in); end
    bus.exec_done = 1'b1;
    tick(1);
    bus.exec_done = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.host_ready !== 1'b1) begin fails++; $display("FAIL good_done_idle: busy=%b ready=%b want 0 1", bus.busy, bus.host_ready); end
  endtask

  task automatic test_bad_csum();
    int fb, sb;
    fb = addr_log.size();
    sb = start_pulses;
    send_byte(8'h81); send_byte(8'h20); send_byte(8'h80);
    send_byte(8'h60); send_byte(8'h00); send_byte(8'h00);
    tick(3);
    tests++; if (addr_log.size() - fb !== 2) begin fails++; $display("FAIL badcsum_fetch_count: got %0d want 2", addr_log.size() - fb); end
    tests++; if (start_pulses - sb !== 0) begin fails++; $display("FAIL badcsum_start: got %0d want 0", start_pulses - sb); end
    tests++; if (bus.load_error !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL badcsum_error_idle: err=%b busy=%b want 1 0", bus.load_error, bus.busy); end
    send_byte(8'h80);
    tests++; if (bus.load_error !== 1'b0) begin fails++; $display("FAIL badcsum_clear: got %b want 0", bus.load_error); end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    tick(2);
    tests++; if (start_pulses - sb !== 1) begin fails++; $display("FAIL recover_start: got %0d want 1", start_pulses - sb); end
    tests++; if (addr_log[fb+2] !== 6'd0 || data_log[fb+2] !== 16'h1234) begin fails++; $display("FAIL recover_word: addr=%h data=%h want 00 1234", addr_log[fb+2], data_log[fb+2]); end
    finish_run();
  endtask

  task automatic test_bad_tag();
    int fb;
    fb = addr_log.size();
    send_byte(8'h3F);
    tests++; if (bus.load_error !== 1'b1) begin fails++; $display("FAIL badtag_error: got %b want 1", bus.load_error); end
    tests++; if (bus.busy !== 1'b0 || bus.host_ready !== 1'b1) begin fails++; $display("FAIL badtag_idle: busy=%b ready=%b want 0 1", bus.busy, bus.host_ready); end
    tick(3);
    tests++; if (addr_log.size() - fb !== 0) begin fails++; $display("FAIL badtag_fetch: got %0d want 0", addr_log.size() - fb); end
  endtask

  task automatic test_full_frame();
    logic [7:0] payload[128];
    logic [7:0] sum;
    int fb, sb;
    fb = addr_log.size();
    sb = start_pulses;
    sum = 8'h00;
    for (int i = 0; i < 128; i++) begin
      payload[i] = 8'($urandom);
      sum = sum ^ payload[i];
    end
    send_byte_gap(8'hBF);
    for (int i = 0; i < 128; i++) send_byte_gap(payload[i]);
    tick(3);
    tests++; if (start_pulses - sb !== 0) begin fails++; $display("FAIL full_early_start: got %0d want 0", start_pulses - sb); end
    tests++; if (bus.load_error !== 1'b0) begin fails++; $display("FAIL full_error_cleared: got %b want 0", bus.load_error); end
    send_byte_gap(sum);
    tick(3);
    tests++; if (addr_log.size() - fb !== 64) begin fails++; $display("FAIL full_fetch_count: got %0d want 64", addr_log.size() - fb); end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (addr_log[fb+i] !== 6'(i) || data_log[fb+i] !== {payload[2*i], payload[2*i+1]}) begin
        fails++;
        $display("FAIL full_word%0d: addr=%h data=%h want %h %h", i, addr_log[fb+i], data_log[fb+i], 6'(i), {payload[2*i], payload[2*i+1]});
      end
    end
    tests++; if (start_pulses - sb !== 1) begin fails++; $display("FAIL full_start: got %0d want 1", start_pulses - sb); end
    finish_run();
  endtask

  task automatic test_reset_midframe();
    int fb, sb;
    fb = addr_log.size();
    sb = start_pulses;
    send_byte(8'h87);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    reset = 1'b0;
    tick(1);
    tests++; if (bus.fetch_ins !== 1'b0 || bus.start !== 1'b0 || bus.busy !== 1'b0 || bus.host_ready !== 1'b0) begin
      fails++; $display("FAIL midreset_ctrl: fetch=%b start=%b busy=%b ready=%b want 0 0 0 0", bus.fetch_ins, bus.start, bus.busy, bus.host_ready);
    end
    tests++; if (bus.dma_address !== 6'd0 || bus.ui_in !== 16'h0000 || bus.load_error !== 1'b0) begin
      fails++; $display("FAIL midreset_data: addr=%h ui=%h err=%b want 00 0000 0", bus.dma_address, bus.ui_in, bus.load_error);
    end
    reset = 1'b1;
    tick(3);
    tests++; if (addr_log.size() - fb !== 3 || start_pulses - sb !== 0) begin
      fails++; $display("FAIL midreset_partial: fetches=%0d starts=%0d want 3 0", addr_log.size() - fb, start_pulses - sb);
    end
    send_byte(8'h81); send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h22);
    tick(2);
    tests++; if (addr_log[fb+3] !== 6'd0 || data_log[fb+3] !== 16'hDEAD) begin fails++; $display("FAIL reload_word0: addr=%h data=%h want 00 dead", addr_log[fb+3], data_log[fb+3]); end
    tests++; if (addr_log[fb+4] !== 6'd1 || data_log[fb+4] !== 16'hBEEF) begin fails++; $display("FAIL reload_word1: addr=%h data=%h want 01 beef", addr_log[fb+4], data_log[fb+4]); end
    tests++; if (start_pulses - sb !== 1) begin fails++; $display("FAIL reload_start: got %0d want 1", start_pulses - sb); end
    finish_run();
  endtask

  task automatic test_run_hold();
    int fb;
    fb = addr_log.size();
    send_byte(8'h80); send_byte(8'h55); send_byte(8'hAA); send_byte(8'hFF);
    tick(2);
    bus.host_data  = 8'h80;
    bus.host_valid = 1'b1;
    tick(3);
    tests++; if (bus.host_ready !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL run_hold: ready=%b busy=%b want 0 1", bus.host_ready, bus.busy); end
    tests++; if (addr_log.size() - fb !== 1 || bus.load_error !== 1'b0) begin fails++; $display("FAIL run_ignore: fetches=%0d err=%b want 1 0", addr_log.size() - fb, bus.load_error); end
    bus.exec_done  = 1'b1;
    bus.host_valid = 1'b0;
    tick(1);
    bus.exec_done = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.host_ready !== 1'b1) begin fails++; $display("FAIL run_exit: busy=%b ready=%b want 0 1", bus.busy, bus.host_ready); end
  endtask

  initial begin
    bus.host_data  = 8'h00;
    bus.host_valid = 1'b0;
    bus.exec_done  = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_tag();
    test_full_frame();
    test_reset_midframe();
    test_run_hold();
    tick(2);
    tests++; if (overlaps !== 0) begin fails++; $display("FAIL start_fetch_overlap: got %0d want 0", overlaps); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous active-low reset; sampled only on the clk rising edge.
REQ-003 SHALL have host_data, input, 8, byte stream from the host.
REQ-004 SHALL have host_valid, input, 1, host_data valid.
REQ-005 SHALL have host_ready, output, 1, loader can accept a byte; a transfer occurs when host_valid and host_ready are both 1.
REQ-006 SHALL have exec_done, input, 1, level from the execution sequencer; program finished.
REQ-007 SHALL have fetch_ins, output, 1, one-cycle instruction-memory write strobe.
REQ-008 SHALL have dma_address, output, 6, instruction-memory write address.
REQ-009 SHALL have ui_in, output, 16, instruction word to write.
REQ-010 SHALL have start, output, 1, one-cycle execution start pulse.
REQ-011 SHALL have busy, output, 1, 1 in every state except IDLE.
REQ-012 SHALL have load_error, output, 1, sticky error flag.

Function
REQ-013 SHALL implement states IDLE, RECV_HI, RECV_LO, RECV_CSUM, START, RUN.
REQ-014 Frame format SHALL be: header byte, then 2N payload bytes (high byte first per word), then one checksum byte.
REQ-015 Header SHALL be bits[7:6]=2'b10 (tag) and bits[5:0]=N-1, giving N=1..64.
REQ-016 host_ready SHALL be 1 in IDLE, RECV_HI, RECV_LO and RECV_CSUM, and 0 in START and RUN.
REQ-017 In IDLE, an accepted byte with a valid tag SHALL latch N-1, clear the word index and checksum, clear load_error, and move to RECV_HI.
REQ-018 In IDLE, an accepted byte with a bad tag SHALL be dropped, set load_error, and remain in IDLE.
REQ-019 In RECV_HI, an accepted byte SHALL be stored as the high byte and move to RECV_LO.
REQ-020 In RECV_LO, an accepted byte SHALL cause fetch_ins=1 in the next cycle only, with ui_in={hi,lo} and dma_address=word index (latency 1).
REQ-021 After that write, the word index SHALL increment; the state SHALL go to RECV_CSUM if the index equalled N-1, else to RECV_HI.
REQ-022 Checksum SHALL be the 8-bit XOR of all payload bytes; the header and checksum bytes are excluded.
REQ-023 In RECV_CSUM, an accepted byte equal to the checksum SHALL move to START.
REQ-024 In RECV_CSUM, an accepted byte that does not match SHALL set load_error and return to IDLE; start SHALL NOT be asserted.
REQ-025 START SHALL assert start for exactly one cycle, then move to RUN; start and fetch_ins SHALL never be 1 in the same cycle.
REQ-026 RUN SHALL hold until exec_done=1 is sampled, then return to IDLE in the next cycle.
REQ-027 dma_address and ui_in SHALL hold their last values between fetch_ins pulses.
REQ-028 host_valid without host_ready SHALL have no effect; host_data SHALL be sampled only on a transfer.
REQ-029 With N=64, the index SHALL reach 63 and go to RECV_CSUM without wrapping; dma_address SHALL never exceed N-1.

Reset
REQ-030 On reset=0 at a clk edge the block SHALL enter IDLE and clear the index, checksum and latched N.
REQ-031 Output reset values SHALL be: fetch_ins=0, start=0, busy=0, load_error=0, dma_address=0, ui_in=0, host_ready=0 during the reset cycle.
REQ-032 Reset mid-frame SHALL discard the partial frame and SHALL NOT assert start; words already written to instruction memory are not retracted.

Structure
REQ-033 Package tpu_pkg SHALL hold the loader state enum, the header tag constant 2'b10, and the MAX_INSTR=64 constant.
REQ-034 The block SHALL be a single module with no sub-module; byte-to-word assembly and the checksum are too small to split out.

Verification
REQ-035 Frame 0x81, 0x20,0x80, 0x60,0x00, csum 0xC0 -> fetch_ins at addr0 with 0x2080, then at addr1 with 0x6000; one start pulse; busy stays 1 until exec_done.
REQ-036 Same frame with csum 0x00 -> two fetch_ins pulses; no start; load_error=1; IDLE. A following valid header clears load_error.
REQ-037 Header 0x3F (bad tag) -> byte dropped; load_error=1; no fetch_ins; host_ready stays 1.
REQ-038 Header 0xBF with 128 payload bytes and host_valid toggled randomly -> 64 fetch_ins pulses at addr 0..63 in order; no extra pulses; start after the checksum byte.
REQ-039 reset=0 asserted after 3 words of an 8-word frame -> all outputs at reset values next cycle; no start; a new full frame loads correctly.
REQ-040 Bytes driven during RUN -> host_ready=0 and no state change; exec_done=1 -> IDLE and host_ready=1 one cycle later.
